tdm_input: RTL and testbench
============================

// Module: tdm_input
// PURPOSE
//  Receive-side TDM deserializer, the counterpart of the TDM serializer. Shares mclk and
//  the free-running cnt256_n frame counter with it. Bit clock is mclk/4: 64 bits/frame, MSB first.
//  Slot map: bits 0-15 ch1, 16-31 pad(0), 32-47 ch2, 48-63 pad(0).
//  Outputs one parallel word pair per frame, a one-cycle valid strobe and a pad-error flag.
// PARAMETERS
//  SAMPLE_PHASE  2  cnt256_n[1:0] value at which (synchronized) tdm_in is sampled
//  SYNC_STAGES   0  input flops on tdm_in (0..2); require SAMPLE_PHASE-SYNC_STAGES in 1..3
//  CHECK_PAD     1  1: check pad slots for zero; 0: pad_err tied to 0
// PORTS
//  mclk         in   1   master clock, all logic on posedge
//  rst_n        in   1   synchronous reset, active low
//  cnt256_n     in   8   frame counter, wraps 255->0, 0 = frame start
//  tdm_in       in   1   serial TDM data, bit k stable while cnt256_n in 4k+1..4k+4
//  ch1_out      out  16  channel 1 word of last complete frame
//  ch2_out      out  16  channel 2 word of last complete frame
//  frame_valid  out  1   one-cycle strobe: ch1_out/ch2_out/pad_err updated
//  pad_err      out  1   1 = a '1' was sampled in any pad slot of that frame
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): ch1_out=0, ch2_out=0, frame_valid=0, pad_err=0;
//    shift regs, pad accumulator, sync flops cleared; armed=0. Reset wins over all.
//  - Input path: tdm_in -> SYNC_STAGES flops -> din. With SYNC_STAGES=0, din=tdm_in.
//  - Sampling: on posedge with cnt256_n[1:0]==SAMPLE_PHASE, bit index k=cnt256_n[7:2]:
//    k 0-15  -> sh1 <= {sh1[14:0],din}
//    k 32-47 -> sh2 <= {sh2[14:0],din}
//    k 16-31, 48-63 -> padacc <= padacc | din (only if CHECK_PAD)
//  - Frame boundary: on posedge with cnt256_n==0:
//    if armed: ch1_out<=sh1, ch2_out<=sh2, pad_err<=padacc, frame_valid<=1
//    always: padacc<=0, armed<=1
//  - frame_valid=0 on every other posedge. It is high only while cnt256_n==1.
//    So rate is exactly one per 256 mclk.
//  - Outputs hold between strobes. A sample at cnt 255 (phase 3) falls before the boundary edge.
//  - Arming: the first cnt256_n==0 after reset only arms and discards the partial frame.
//    The first strobe is at the second cnt256_n==0.
//  - Reset mid-frame: partial data discarded. Same arming sequence as power-up.
//  - Latency: last data bit (k=47) to strobe < 1 frame. Strobe 1 cycle after frame wrap.
//  - No checking of cnt256_n continuity; a jump is treated as normal counting.
// TESTING
//  1 Loopback from serializer model, ch1=16'hA5C3, ch2=16'h1234 -> frame_valid at cnt==1
//    two frames after reset, ch1_out=A5C3, ch2_out=1234, pad_err=0.
//  2 Release rst_n at cnt=100 -> no strobe at next cnt==0; first strobe one frame later.
//  3 Force tdm_in=1 during slot 20 (cnt 81..84) -> that frame pad_err=1, data intact;
//    next clean frame pad_err=0; CHECK_PAD=0 build -> pad_err stays 0.
//  4 rst_n low at cnt=130 for 3 cycles -> outputs 0 immediately; partial frame never strobed.
//  5 Bit order: ch1=FFFF/ch2=0000, then 8000/0001 -> exact words; all SAMPLE_PHASE/SYNC_STAGES
//    legal combos (P2S0, P3S2, P1S0) give identical results.
//  6 Four back-to-back frames, distinct values -> exactly 4 strobes 256 cycles apart,
//    outputs stable between strobes.

Source files
------------

// File: rtl/tdm_input_if.sv
// Bus between the TDM deserializer and its surroundings: shared frame counter and serial
// input in, one parallel word pair per frame out.
interface tdm_input_if;
    logic [7:0]  cnt256_n;
    logic        tdm_in;
    logic [15:0] ch1_out;
    logic [15:0] ch2_out;
    logic        frame_valid;
    logic        pad_err;

    modport master (
        output cnt256_n, tdm_in,
        input  ch1_out, ch2_out, frame_valid, pad_err
    );

    modport slave (
        input  cnt256_n, tdm_in,
        output ch1_out, ch2_out, frame_valid, pad_err
    );
endinterface

// File: rtl/tdm_input.sv
// Receive-side TDM deserializer: 64-bit frames (ch1, pad, ch2, pad) at mclk/4, MSB first,
// delivered as one word pair per frame with a one-cycle strobe and a pad-error flag.
module tdm_input #(
    parameter int SAMPLE_PHASE = 2,  // legal when SAMPLE_PHASE-SYNC_STAGES is 1..3
    parameter int SYNC_STAGES  = 0,
    parameter int CHECK_PAD    = 1
) (
    input  logic        mclk,
    input  logic        rst_n,
    tdm_input_if.slave  bus
);

    logic        w_din;
    logic [5:0]  w_bit;
    logic        w_sample;
    logic        w_boundary;

    logic [15:0] r_sh1;
    logic [15:0] r_sh2;
    logic [15:0] r_ch1;
    logic [15:0] r_ch2;
    logic        r_padacc;
    logic        r_armed;
    logic        r_valid;
    logic        r_pad_err;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_din = bus.tdm_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            // NOTE: reset is synchronous, so it lives inside the clocked branch and the
            // sensitivity list carries only the clock.
            always_ff @(posedge mclk) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= bus.tdm_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_din = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_bit      = bus.cnt256_n[7:2];
    assign w_sample   = (bus.cnt256_n[1:0] == 2'(SAMPLE_PHASE));
    assign w_boundary = (bus.cnt256_n == 8'd0);

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_sh1     <= '0;
            r_sh2     <= '0;
            r_ch1     <= '0;
            r_ch2     <= '0;
            r_padacc  <= 1'b0;
            r_armed   <= 1'b0;
            r_valid   <= 1'b0;
            r_pad_err <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            // Slot map by bit index: 0-15 ch1, 32-47 ch2, everything else is pad.
            if (w_sample) begin
                if (w_bit[5:4] == 2'b00) begin
                    r_sh1 <= {r_sh1[14:0], w_din};
                end else if (w_bit[5:4] == 2'b10) begin
                    r_sh2 <= {r_sh2[14:0], w_din};
                end else if (CHECK_PAD != 0) begin
                    r_padacc <= r_padacc | w_din;
                end
            end

            // NOTE: with non-blocking assignments the last one in program order wins, so
            // the boundary clear of r_padacc below takes priority over any pad update above.
            if (w_boundary) begin
                if (r_armed) begin
                    r_ch1     <= r_sh1;
                    r_ch2     <= r_sh2;
                    r_pad_err <= r_padacc;
                    r_valid   <= 1'b1;
                end
                r_padacc <= 1'b0;
                r_armed  <= 1'b1;
            end
        end
    end

    assign bus.ch1_out     = r_ch1;
    assign bus.ch2_out     = r_ch2;
    assign bus.frame_valid = r_valid;
    assign bus.pad_err     = r_pad_err;

endmodule

// File: tb/tb_tdm_input.sv
// Self-checking bench: a serializer model drives four deserializer builds sharing one
// counter; a per-frame model predicts the outputs, checked every cycle plus literal anchors.
module tb_tdm_input;

    typedef struct {
        logic [15:0] ch1;
        logic [15:0] ch2;
        int          pad_slot;  // -1: no forced '1' in a pad slot
    } frame_t;

    logic       mclk = 1'b0;
    logic       rst_n;
    logic [7:0] cnt;
    logic       tdm_in;

    int n_vec = 0;
    int n_err = 0;

    frame_t q[$];
    frame_t cur;

    // Expected outputs derived from the per-frame rule
    logic [15:0] exp_ch1 = '0;
    logic [15:0] exp_ch2 = '0;
    logic        exp_pad = 1'b0;
    logic        exp_valid = 1'b0;
    bit          m_armed = 1'b0;
    bit          started = 1'b0;

    always #5 mclk = ~mclk;

    tdm_input_if if_a ();
    tdm_input_if if_b ();
    tdm_input_if if_c ();
    tdm_input_if if_d ();

    assign if_a.cnt256_n = cnt;
    assign if_b.cnt256_n = cnt;
    assign if_c.cnt256_n = cnt;
    assign if_d.cnt256_n = cnt;
    assign if_a.tdm_in   = tdm_in;
    assign if_b.tdm_in   = tdm_in;
    assign if_c.tdm_in   = tdm_in;
    assign if_d.tdm_in   = tdm_in;

    tdm_input #(.SAMPLE_PHASE(2), .SYNC_STAGES(0), .CHECK_PAD(1))
        u_p2s0 (.mclk(mclk), .rst_n(rst_n), .bus(if_a.slave));
    tdm_input #(.SAMPLE_PHASE(3), .SYNC_STAGES(2), .CHECK_PAD(1))
        u_p3s2 (.mclk(mclk), .rst_n(rst_n), .bus(if_b.slave));
    tdm_input #(.SAMPLE_PHASE(1), .SYNC_STAGES(0), .CHECK_PAD(1))
        u_p1s0 (.mclk(mclk), .rst_n(rst_n), .bus(if_c.slave));
    tdm_input #(.SAMPLE_PHASE(2), .SYNC_STAGES(1), .CHECK_PAD(0))
        u_nopad (.mclk(mclk), .rst_n(rst_n), .bus(if_d.slave));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t cnt=%0d)", name, act, exp, $time, cnt);
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        f.ch1 = 16'($urandom);
        f.ch2 = 16'($urandom);
        if ($urandom_range(0, 3) == 0)
            f.pad_slot = ($urandom_range(0, 1) == 1) ? int'($urandom_range(16, 31))
                                                     : int'($urandom_range(48, 63));
        else
            f.pad_slot = -1;
        return f;
    endfunction

    // Serializer model: bit k of the frame is presented while cnt is 4k+1..4k+4.
    task automatic drive_bit();
        logic [7:0]  c1;
        logic [63:0] fb;
        int          k;
        c1 = cnt - 8'd1;
        k  = int'(c1[7:2]);
        fb = {cur.ch1, 16'h0000, cur.ch2, 16'h0000};
        tdm_in = fb[63-k] | (k == cur.pad_slot);
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
        cnt = cnt + 8'd1;
        if (cnt == 8'd1) begin
            if (q.size() > 0) cur = q.pop_front();
            else              cur = rand_frame();
        end
        drive_bit();
    endtask

    task automatic run_to(input logic [7:0] target);
        do step(); while (cnt != target);
    endtask

    // Per-frame model: the completed frame's words appear one edge after its last counter value.
    always @(posedge mclk) begin
        started = 1'b1;
        if (!rst_n) begin
            exp_ch1   = '0;
            exp_ch2   = '0;
            exp_pad   = 1'b0;
            exp_valid = 1'b0;
            m_armed   = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (cnt == 8'd0) begin
                if (m_armed) begin
                    exp_ch1   = cur.ch1;
                    exp_ch2   = cur.ch2;
                    exp_pad   = (cur.pad_slot >= 0);
                    exp_valid = 1'b1;
                end
                m_armed = 1'b1;
            end
        end
    end

    task automatic cmp_dut(input string tag, input logic [15:0] c1, input logic [15:0] c2,
                           input logic v, input logic p, input bit nopad);
        check({tag, ".frame_valid"}, 16'(v), 16'(exp_valid));
        check({tag, ".ch1_out"}, c1, exp_ch1);
        check({tag, ".ch2_out"}, c2, exp_ch2);
        check({tag, ".pad_err"}, 16'(p), nopad ? 16'h0 : 16'(exp_pad));
    endtask

    always @(negedge mclk) begin
        if (started) begin
            cmp_dut("p2s0",  if_a.ch1_out, if_a.ch2_out, if_a.frame_valid, if_a.pad_err, 1'b0);
            cmp_dut("p3s2",  if_b.ch1_out, if_b.ch2_out, if_b.frame_valid, if_b.pad_err, 1'b0);
            cmp_dut("p1s0",  if_c.ch1_out, if_c.ch2_out, if_c.frame_valid, if_c.pad_err, 1'b0);
            cmp_dut("nopad", if_d.ch1_out, if_d.ch2_out, if_d.frame_valid, if_d.pad_err, 1'b1);
        end
    end

    // Literal anchors for both the model and one build
    task automatic anchor(input string tag, input logic v, input logic [15:0] c1,
                          input logic [15:0] c2, input logic p);
        @(negedge mclk);
        check({tag, ".model.valid"}, 16'(exp_valid), 16'(v));
        check({tag, ".model.ch1"},   exp_ch1, c1);
        check({tag, ".model.ch2"},   exp_ch2, c2);
        check({tag, ".model.pad"},   16'(exp_pad), 16'(p));
        check({tag, ".dut.valid"},   16'(if_a.frame_valid), 16'(v));
        check({tag, ".dut.ch1"},     if_a.ch1_out, c1);
        check({tag, ".dut.ch2"},     if_a.ch2_out, c2);
        check({tag, ".dut.pad"},     16'(if_a.pad_err), 16'(p));
    endtask

    initial begin
        int rst_left;
        rst_n = 1'b0;
        cnt   = 8'd90;
        cur   = rand_frame();
        drive_bit();
        q.push_back('{16'hA5C3, 16'h1234, -1});
        q.push_back('{16'hFFFF, 16'h0000, -1});
        q.push_back('{16'h8000, 16'h0001, -1});
        q.push_back('{16'h5A5A, 16'hC3C3, 20});
        q.push_back('{16'h0F0F, 16'hF0F0, -1});

        // Reset released at cnt 100: the next wrap only arms
        run_to(8'd100);
        rst_n = 1'b1;
        run_to(8'd1);
        anchor("arm_only", 1'b0, 16'h0000, 16'h0000, 1'b0);
        run_to(8'd1);
        anchor("loopback", 1'b1, 16'hA5C3, 16'h1234, 1'b0);
        step();
        @(negedge mclk);
        check("strobe_one_cycle", 16'(if_a.frame_valid), 16'h0);
        run_to(8'd1);
        anchor("ones_zeros", 1'b1, 16'hFFFF, 16'h0000, 1'b0);
        run_to(8'd1);
        anchor("msb_lsb", 1'b1, 16'h8000, 16'h0001, 1'b0);
        run_to(8'd1);
        anchor("pad_slot20", 1'b1, 16'h5A5A, 16'hC3C3, 1'b1);
        check("nopad.pad_slot20", 16'(if_d.pad_err), 16'h0);
        run_to(8'd1);
        anchor("pad_clean", 1'b1, 16'h0F0F, 16'hF0F0, 1'b0);

        // Mid-frame reset at cnt 130 for three edges
        run_to(8'd130);
        rst_n = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b1;
        anchor("mid_reset", 1'b0, 16'h0000, 16'h0000, 1'b0);
        run_to(8'd1);
        anchor("rearm_only", 1'b0, 16'h0000, 16'h0000, 1'b0);

        // Randomized frames with occasional short resets
        rst_left = 0;
        for (int i = 0; i < 40 * 256; i++) begin
            step();
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 2999) == 0) begin
                rst_n    = 1'b0;
                rst_left = int'($urandom_range(1, 5));
            end
        end
        rst_n = 1'b1;
        run_to(8'd2);
        @(posedge mclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
